phy_rx_deframer: RTL

PHY_RX_DEFRAMER -- requirements
Module: phy_rx_deframer

---
 rtl/phy_rx_deframer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/phy_rx_deframer.sv
// Receive-side deframer: splits the K/D symbol stream into TLP/DLLP payload bytes and ordered sets.
// Define PHY_RX_LEN_CHECK_EN to abort TLPs longer than MAX_TLP_LEN bytes.
module phy_rx_deframer #(
    parameter int MAX_TLP_LEN = 64,
    parameter int DLLP_LEN    = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] RX_DATA,
    input  logic       RX_K,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       PKT_TYPE,
    output logic       PKT_START,
    output logic       PKT_END,
    output logic       PKT_NULL,
    output logic       OS_VALID,
    output logic [1:0] OS_TYPE,
    output logic       ERROR_DLL
);

    localparam int CW = $clog2(MAX_TLP_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_TLP_LEN);
    localparam logic [CW-1:0] DLLP_CNT = CW'(DLLP_LEN);

`ifdef PHY_RX_LEN_CHECK_EN
    localparam logic LEN_CHECK = 1'b1;
`else
    localparam logic LEN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_TLP, S_DLLP, S_OS} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_os_cnt;
    logic [1:0]      r_os_sym;
    logic [7:0]      r_data_out;
    logic            r_data_valid;
    logic            r_pkt_type;
    logic            r_pkt_start;
    logic            r_pkt_end;
    logic            r_pkt_null;
    logic            r_os_valid;
    logic [1:0]      r_os_type;
    logic            r_error;

    logic            w_is_stp;
    logic            w_is_sdp;
    logic            w_is_end;
    logic            w_is_edb;
    logic            w_is_com;
    logic            w_is_start;
    logic [1:0]      w_os_code;
    logic            w_is_os;
    logic            w_len_abort;
    state_t          w_start_state;

    assign w_is_stp   = RX_K && (RX_DATA == 8'hFB);
    assign w_is_sdp   = RX_K && (RX_DATA == 8'h5C);
    assign w_is_end   = RX_K && (RX_DATA == 8'hFD);
    assign w_is_edb   = RX_K && (RX_DATA == 8'hFE);
    assign w_is_com   = RX_K && (RX_DATA == 8'hBC);
    assign w_is_start = w_is_stp || w_is_sdp || w_is_com;
    assign w_is_os    = (w_os_code != 2'b00);
    assign w_len_abort = LEN_CHECK && (r_state == S_TLP) && (r_cnt == MAX_CNT);

    always_comb begin
        w_os_code = 2'b00;
        if (RX_K) begin
            case (RX_DATA)
                8'h1C:   w_os_code = 2'b01;
                8'h7C:   w_os_code = 2'b10;
                8'h3C:   w_os_code = 2'b11;
                default: w_os_code = 2'b00;
            endcase
        end
    end

    always_comb begin
        w_start_state = S_IDLE;
        if (w_is_stp)      w_start_state = S_TLP;
        else if (w_is_sdp) w_start_state = S_DLLP;
        else if (w_is_com) w_start_state = S_OS;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_os_cnt     <= 2'd0;
            r_os_sym     <= 2'b00;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_pkt_type   <= 1'b0;
            r_pkt_start  <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_pkt_null   <= 1'b0;
            r_os_valid   <= 1'b0;
            r_os_type    <= 2'b00;
            r_error      <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_pkt_start  <= 1'b0;
            r_pkt_end    <= 1'b0;
            r_pkt_null   <= 1'b0;
            r_os_valid   <= 1'b0;
            r_error      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_start) begin
                        r_state  <= w_start_state;
                        r_cnt    <= '0;
                        r_os_cnt <= 2'd0;
                    end else if (RX_K) begin
                        r_error <= 1'b1;
                    end
                end
                S_TLP, S_DLLP: begin
                    if (!RX_K) begin
                        if (w_len_abort) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_data_out   <= RX_DATA;
                            r_data_valid <= 1'b1;
                            r_pkt_type   <= (r_state == S_DLLP);
                            r_pkt_start  <= (r_cnt == '0);
                            // Saturate so long TLPs keep flowing when the length check is off
                            if (r_cnt != MAX_CNT)
                                r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_is_end) begin
                        r_state    <= S_IDLE;
                        r_pkt_type <= (r_state == S_DLLP);
                        if ((r_state == S_TLP) ? (r_cnt != '0) : (r_cnt == DLLP_CNT))
                            r_pkt_end <= 1'b1;
                        else
                            r_error <= 1'b1;
                    end else if (w_is_edb) begin
                        r_state <= S_IDLE;
                        if (r_state == S_TLP)
                            r_pkt_null <= 1'b1;
                        else
                            r_error <= 1'b1;
                    end else begin
                        // Aborted packet; a start symbol opens the next one immediately
                        r_error  <= 1'b1;
                        r_state  <= w_start_state;
                        r_cnt    <= '0;
                        r_os_cnt <= 2'd0;
                    end
                end
                S_OS: begin
                    if (w_is_com) begin
                        r_os_cnt <= 2'd0;
                    end else if (w_is_os && (r_os_cnt == 2'd0 || w_os_code == r_os_sym)) begin
                        r_os_sym <= w_os_code;
                        if (r_os_cnt == 2'd2) begin
                            r_os_valid <= 1'b1;
                            r_os_type  <= w_os_code;
                            r_state    <= S_IDLE;
                        end else begin
                            r_os_cnt <= r_os_cnt + 2'd1;
                        end
                    end else begin
                        r_error <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign DATA_OUT   = r_data_out;
    assign DATA_VALID = r_data_valid;
    assign PKT_TYPE   = r_pkt_type;
    assign PKT_START  = r_pkt_start;
    assign PKT_END    = r_pkt_end;
    assign PKT_NULL   = r_pkt_null;
    assign OS_VALID   = r_os_valid;
    assign OS_TYPE    = r_os_type;
    assign ERROR_DLL  = r_error;

endmodule
